// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: switch field widths, debounce lengths and counter sizing shared with the ALU front end.
package switch_debounce_pkg;

    localparam int OPERAND_W           = 4;
    localparam int OP_W                = 3;
    localparam int SW_W                = 2 * OPERAND_W + OP_W;
    localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    // Sized to hold STABLE_CYCLES+2, the settling counter's terminal value.
    function automatic int cnt_w(int stable_cycles);
        return $clog2(stable_cycles + 3);
    endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch vector in, debounced vector plus change/valid flags out.
interface switch_debounce_if import switch_debounce_pkg::*; #(
    parameter int WIDTH = SW_W
);

    logic [WIDTH-1:0] sw_i;
    logic [WIDTH-1:0] sw_o;
    logic             changed_o;
    logic             valid_o;

    modport master (output sw_i, input sw_o, changed_o, valid_o);
    modport slave  (input sw_i, output sw_o, changed_o, valid_o);

endinterface

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: one switch bit - 2-flop synchroniser, stability counter, accepted level and update strobe.
module switch_debounce_bit import switch_debounce_pkg::*; #(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sw_i,
    output logic sw_o,
    output logic upd
);

    localparam int              CNT_W = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    assign upd = (sync2 != sw_o) && (cnt == LAST);

    // Any return to the accepted level restarts the count from zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            sw_o  <= 1'b0;
        end else begin
            sync1 <= sw_i;
            sync2 <= sync1;
            cnt   <= (sync2 == sw_o || upd) ? '0 : cnt + 1'b1;
            if (upd) sw_o <= sync2;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: per-bit debouncers feeding the ALU mux, plus a merged change strobe and a post-reset valid flag.
module switch_debounce import switch_debounce_pkg::*; #(
    parameter int WIDTH         = SW_W,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic               clk_i,
    input  logic               reset_i,
    switch_debounce_if.slave   bus
);

    localparam int               CNT_W  = cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(STABLE_CYCLES + 2);

    if (STABLE_CYCLES < 1) begin : g_bad_param
        $error("switch_debounce: STABLE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] upd;
    logic [CNT_W-1:0] settle;
    logic             changed;
    logic             valid;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        switch_debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .sw_i    (bus.sw_i[b]),
            .sw_o    (sw_q[b]),
            .upd     (upd[b])
        );
    end

    // valid rises on the same edge a level held through reset reaches sw_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            changed <= 1'b0;
            valid   <= 1'b0;
            settle  <= '0;
        end else begin
            changed <= |upd;
            valid   <= valid | (settle == SETTLE - 1'b1);
            if (settle != SETTLE) settle <= settle + 1'b1;
        end
    end

    assign bus.sw_o      = sw_q;
    assign bus.changed_o = changed;
    assign bus.valid_o   = valid;

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: cycle-by-cycle vector table through a scoreboard queue, STABLE_CYCLES = 4.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int SC = DEBOUNCE_CYCLES_SIM;

    typedef struct {
        string           nm;
        logic            rst;
        logic [SW_W-1:0] sw;
        logic [SW_W-1:0] esw;
        logic            chg;
        logic            val;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;

    switch_debounce_if #(.WIDTH(SW_W)) bus ();

    switch_debounce #(.WIDTH(SW_W), .STABLE_CYCLES(SC)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input string nm, input logic r, input logic [SW_W-1:0] s,
                       input logic [SW_W-1:0] e, input logic c, input logic v, input int n);
        vec_t x;
        x = '{nm, r, s, e, c, v};
        repeat (n) vecs.push_back(x);
    endtask

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL: timeout waiting for vector run to complete");
            $finish;
        end
    end

    initial begin
        vec_t e;
        bus.sw_i = '0;
        // reset with every switch held high, then release
        add("reset_hold",  1, 11'h7FF, 11'h000, 0, 0, 2);
        add("reset_rel",   0, 11'h7FF, 11'h000, 0, 0, 5);
        add("reset_edge6", 0, 11'h7FF, 11'h7FF, 1, 1, 1);
        add("reset_after", 0, 11'h7FF, 11'h7FF, 0, 1, 2);
        add("all_fall",    0, 11'h000, 11'h7FF, 0, 1, 5);
        add("all_fall6",   0, 11'h000, 11'h000, 1, 1, 1);
        add("all_fall7",   0, 11'h000, 11'h000, 0, 1, 2);
        // clean single-bit step
        add("step0",       0, 11'h001, 11'h000, 0, 1, 5);
        add("step0_e6",    0, 11'h001, 11'h001, 1, 1, 1);
        add("step0_hold",  0, 11'h001, 11'h001, 0, 1, 2);
        add("step0_fall",  0, 11'h000, 11'h001, 0, 1, 5);
        add("step0_fe6",   0, 11'h000, 11'h000, 1, 1, 1);
        add("step0_fh",    0, 11'h000, 11'h000, 0, 1, 1);
        // bounce on bit 3: 1,0,1,0 two cycles each, then held high
        add("bounce_a",    0, 11'h008, 11'h000, 0, 1, 2);
        add("bounce_b",    0, 11'h000, 11'h000, 0, 1, 2);
        add("bounce_c",    0, 11'h008, 11'h000, 0, 1, 2);
        add("bounce_d",    0, 11'h000, 11'h000, 0, 1, 2);
        add("bounce_hold", 0, 11'h008, 11'h000, 0, 1, 5);
        add("bounce_e6",   0, 11'h008, 11'h008, 1, 1, 1);
        add("bounce_post", 0, 11'h008, 11'h008, 0, 1, 1);
        add("bounce_fall", 0, 11'h000, 11'h008, 0, 1, 5);
        add("bounce_fe6",  0, 11'h000, 11'h000, 1, 1, 1);
        add("bounce_fh",   0, 11'h000, 11'h000, 0, 1, 1);
        // three-cycle glitch on bit 5 must be rejected
        add("glitch_hi",   0, 11'h020, 11'h000, 0, 1, 3);
        add("glitch_lo",   0, 11'h000, 11'h000, 0, 1, 6);
        // two bits rising together give one pulse
        add("dual",        0, 11'h401, 11'h000, 0, 1, 5);
        add("dual_e6",     0, 11'h401, 11'h401, 1, 1, 1);
        add("dual_hold",   0, 11'h401, 11'h401, 0, 1, 2);
        add("dual_fall",   0, 11'h000, 11'h401, 0, 1, 5);
        add("dual_fe6",    0, 11'h000, 11'h000, 1, 1, 1);
        add("dual_fh",     0, 11'h000, 11'h000, 0, 1, 1);
        // reset lands mid-count on bit 2
        add("mid_count",   0, 11'h004, 11'h000, 0, 1, 4);
        add("mid_reset",   1, 11'h004, 11'h000, 0, 0, 1);
        add("mid_rel",     0, 11'h004, 11'h000, 0, 0, 5);
        add("mid_e6",      0, 11'h004, 11'h004, 1, 1, 1);
        add("mid_hold",    0, 11'h004, 11'h004, 0, 1, 2);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            bus.sw_i = vecs[i].sw;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({bus.sw_o, bus.changed_o, bus.valid_o} !== {e.esw, e.chg, e.val}) begin
                n_err++;
                $display("FAIL %s row %0d: got sw_o=%h changed_o=%b valid_o=%b, expected sw_o=%h changed_o=%b valid_o=%b",
                         e.nm, i, bus.sw_o, bus.changed_o, bus.valid_o, e.esw, e.chg, e.val);
            end
            if (e.rst && {bus.sw_o, bus.changed_o, bus.valid_o} !== '0) begin
                n_err++;
                $display("FAIL %s row %0d: reset state not cleared, sw_o=%h changed_o=%b valid_o=%b",
                         e.nm, i, bus.sw_o, bus.changed_o, bus.valid_o);
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0) $display("FAIL: %0d miscompares", n_err);
        else $display("PASS");
        $finish;
    end

endmodule
